dct_row_loader: RTL and testbench

DCT_ROW_LOADER -- requirements
Module: dct_row_loader

---
 rtl/dct_pkg.sv | 41 ++++
 rtl/dct_row_loader_if.sv | 32 +++
 rtl/dct_valid_delay.sv | 44 ++++
 rtl/dct_row_loader.sv | 157 +++++++++++++++
 tb/tb_dct_row_loader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dct_pkg.sv
// ---------------------------------------------------------------------------
// dct_pkg
// Shared constants and types for the DCT row loader slice.
//   PIX_W       : pixel / sample width
//   N_PT        : points per DCT row (slots per row, rows per block)
//   DCT_LAT_DEF : default latency of the downstream dct core
//   row_idx_t   : 3-bit row/column index within an 8x8 block
//   sample_t    : signed sample presented to the dct inputs
//   row_tag_t   : {valid,row,last} tag carried alongside a row
// Optional feature macro: DCT_LEVEL_SHIFT_EN (pixels are unsigned and are
// re-centred around zero before being stored).
// ---------------------------------------------------------------------------
package dct_pkg;

    localparam int PIX_W       = 8;
    localparam int N_PT        = 8;
    localparam int DCT_LAT_DEF = 4;

    typedef logic [2:0]              row_idx_t;
    typedef logic signed [PIX_W-1:0] sample_t;

    typedef struct packed {
        logic     valid;
        row_idx_t row;
        logic     last;
    } row_tag_t;

    // Converts a raw pixel into the sample the dct expects.
`ifdef DCT_LEVEL_SHIFT_EN
    // Flipping the MSB of an unsigned byte equals subtracting 128 in two's
    // complement, so 0..255 maps onto -128..127.
    function automatic sample_t pix_to_sample(input logic [PIX_W-1:0] p);
        return $signed(p ^ {1'b1, {(PIX_W-1){1'b0}}});
    endfunction
`else
    function automatic sample_t pix_to_sample(input logic [PIX_W-1:0] p);
        return $signed(p);
    endfunction
`endif

endpackage

// File: rtl/dct_row_loader_if.sv
// ---------------------------------------------------------------------------
// dct_row_loader_if
// Pixel stream into the row loader.
//   pix_valid : pixel strobe from upstream
//   pix_ready : loader can accept a pixel
//   pix_data  : pixel sample
//   pix_sof   : marks the first pixel of an 8x8 block (qualified by valid)
// Modports: master = upstream pixel source, slave = row loader.
// ---------------------------------------------------------------------------
interface dct_row_loader_if;
    import dct_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_sof,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_sof,
        output pix_ready
    );

endinterface

// File: rtl/dct_valid_delay.sv
// ---------------------------------------------------------------------------
// dct_valid_delay
// Fixed-depth shift register carrying the {valid,row,last} tag of each row
// so that it lines up with the dct outputs.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low clear of every stage
//   tag_in  : tag entering the line
//   tag_out : tag leaving the line, DEPTH cycles later
// ---------------------------------------------------------------------------
module dct_valid_delay
    import dct_pkg::*;
#(
    parameter int DEPTH = DCT_LAT_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    input  row_tag_t tag_in,
    output row_tag_t tag_out
);

    row_tag_t stage_q [DEPTH];
    row_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dct_row_loader.sv
// ---------------------------------------------------------------------------
// dct_row_loader
// Collects eight accepted pixels into a row, presents the row to the dct
// inputs x0..x7 with a one-cycle x_valid strobe, tracks the row index within
// the 8x8 block and re-aligns the block on pix_sof.  The row tag is delayed
// by DCT_LAT cycles so y_valid/y_row/y_last line up with the dct outputs.
//   clk, rst_n       : clock, synchronous active-low reset
//   pix              : pixel stream (slave side of dct_row_loader_if)
//   x0..x7           : row samples to the dct, x0 = first pixel of the row
//   x_valid          : one-cycle pulse, x0..x7 hold a new row
//   x_row, x_last    : row index of x0..x7, last-row flag
//   y_valid/row/last : x_valid/x_row/x_last delayed by DCT_LAT cycles
//   sof_err          : one-cycle pulse when pix_sof arrives mid-block
// Parameter DCT_LAT: legal range 1..16.
// Optional feature macro: DCT_LEVEL_SHIFT_EN (see dct_pkg::pix_to_sample).
// ---------------------------------------------------------------------------
module dct_row_loader
    import dct_pkg::*;
#(
    parameter int DCT_LAT = DCT_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    dct_row_loader_if.slave    pix,
    output sample_t            x0,
    output sample_t            x1,
    output sample_t            x2,
    output sample_t            x3,
    output sample_t            x4,
    output sample_t            x5,
    output sample_t            x6,
    output sample_t            x7,
    output logic               x_valid,
    output row_idx_t           x_row,
    output logic               x_last,
    output logic               y_valid,
    output row_idx_t           y_row,
    output logic               y_last,
    output logic               sof_err
);

    localparam row_idx_t LAST_IDX = row_idx_t'(N_PT - 1);

    sample_t  slot_q [N_PT];
    sample_t  slot_d [N_PT];
    sample_t  xs_q   [N_PT];
    sample_t  xs_d   [N_PT];
    row_idx_t col_q, col_d;
    row_idx_t row_q, row_d;
    row_idx_t x_row_q, x_row_d;
    logic     x_valid_q, x_valid_d;
    logic     x_last_q, x_last_d;
    logic     sof_err_q, sof_err_d;
    logic     pix_ready_q, pix_ready_d;

    logic     accept;
    sample_t  pix_sample;
    row_tag_t tag_in;
    row_tag_t tag_out;

    assign accept     = pix.pix_valid && pix_ready_q;
    assign pix_sample = pix_to_sample(pix.pix_data);

    // The loader never back-pressures once out of reset.  A misaligned
    // sof restarts the block with the sof pixel in slot 0.  The eighth
    // pixel goes straight into x7 since its slot is not yet written.
    always_comb begin
        slot_d      = slot_q;
        xs_d        = xs_q;
        col_d       = col_q;
        row_d       = row_q;
        x_row_d     = x_row_q;
        x_valid_d   = 1'b0;
        x_last_d    = 1'b0;
        sof_err_d   = 1'b0;
        pix_ready_d = 1'b1;

        if (accept) begin
            if (pix.pix_sof && (col_q != '0 || row_q != '0)) begin
                slot_d[0] = pix_sample;
                col_d     = row_idx_t'(1);
                row_d     = '0;
                sof_err_d = 1'b1;
            end else begin
                slot_d[col_q] = pix_sample;
                if (col_q == LAST_IDX) begin
                    for (int i = 0; i < N_PT - 1; i++) begin
                        xs_d[i] = slot_q[i];
                    end
                    xs_d[N_PT-1] = pix_sample;
                    x_valid_d    = 1'b1;
                    x_row_d      = row_q;
                    x_last_d     = (row_q == LAST_IDX);
                    row_d        = row_q + row_idx_t'(1);
                    col_d        = '0;
                end else begin
                    col_d = col_q + row_idx_t'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PT; i++) begin
                slot_q[i] <= '0;
                xs_q[i]   <= '0;
            end
            col_q       <= '0;
            row_q       <= '0;
            x_row_q     <= '0;
            x_valid_q   <= 1'b0;
            x_last_q    <= 1'b0;
            sof_err_q   <= 1'b0;
            pix_ready_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            xs_q        <= xs_d;
            col_q       <= col_d;
            row_q       <= row_d;
            x_row_q     <= x_row_d;
            x_valid_q   <= x_valid_d;
            x_last_q    <= x_last_d;
            sof_err_q   <= sof_err_d;
            pix_ready_q <= pix_ready_d;
        end
    end

    assign tag_in = '{valid: x_valid_q, row: x_row_q, last: x_last_q};

    dct_valid_delay #(
        .DEPTH (DCT_LAT)
    ) u_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign pix.pix_ready = pix_ready_q;
    assign x0      = xs_q[0];
    assign x1      = xs_q[1];
    assign x2      = xs_q[2];
    assign x3      = xs_q[3];
    assign x4      = xs_q[4];
    assign x5      = xs_q[5];
    assign x6      = xs_q[6];
    assign x7      = xs_q[7];
    assign x_valid = x_valid_q;
    assign x_row   = x_row_q;
    assign x_last  = x_last_q;
    assign sof_err = sof_err_q;
    assign y_valid = tag_out.valid;
    assign y_row   = tag_out.row;
    assign y_last  = tag_out.last;

endmodule

// File: tb/tb_dct_row_loader.sv
// ---------------------------------------------------------------------------
// tb_dct_row_loader
// Self-checking bench for dct_row_loader.  A reference model built from
// pixel queues and a list of pending y events predicts every output each
// cycle.  Works with or without DCT_LEVEL_SHIFT_EN defined.
// ---------------------------------------------------------------------------
module tb_dct_row_loader;
    import dct_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        int due;
        int row;
        bit last;
    } y_event_t;

    logic     clk = 1'b0;
    logic     rst_n;
    sample_t  x0, x1, x2, x3, x4, x5, x6, x7;
    logic     x_valid, x_last, y_valid, y_last, sof_err;
    row_idx_t x_row, y_row;

    dct_row_loader_if pif ();

    dct_row_loader #(
        .DCT_LAT (LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix     (pif),
        .x0      (x0),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .x4      (x4),
        .x5      (x5),
        .x6      (x6),
        .x7      (x7),
        .x_valid (x_valid),
        .x_row   (x_row),
        .x_last  (x_last),
        .y_valid (y_valid),
        .y_row   (y_row),
        .y_last  (y_last),
        .sof_err (sof_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int       row_buf[$];
    int       m_row;
    int       m_x[8];
    int       m_xrow;
    bit       m_xvalid, m_xlast, m_sof_err, m_ready;
    y_event_t yq[$];
    int       cyc = 0;

    function automatic int conv(input int d);
`ifdef DCT_LEVEL_SHIFT_EN
        return d - 128;
`else
        return (d >= 128) ? d - 256 : d;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // Advances the model across one clock edge with the given inputs.
    task automatic modelEdge(input bit v, input int d, input bit sof, input bit rn);
        bit acc;
        int p;
        acc = m_ready && v;
        cyc++;
        if (!rn) begin
            row_buf.delete();
            yq.delete();
            m_row = 0;
            foreach (m_x[i]) m_x[i] = 0;
            m_xrow = 0;
            m_xvalid = 0;
            m_xlast = 0;
            m_sof_err = 0;
            m_ready = 0;
        end else begin
            m_xvalid = 0;
            m_xlast = 0;
            m_sof_err = 0;
            m_ready = 1;
            if (acc) begin
                p = conv(d);
                if (sof && (row_buf.size() != 0 || m_row != 0)) begin
                    row_buf.delete();
                    row_buf.push_back(p);
                    m_row = 0;
                    m_sof_err = 1;
                end else begin
                    row_buf.push_back(p);
                    if (row_buf.size() == 8) begin
                        foreach (m_x[i]) m_x[i] = row_buf[i];
                        m_xvalid = 1;
                        m_xrow = m_row;
                        m_xlast = (m_row == 7);
                        yq.push_back('{cyc + LAT, m_row, m_row == 7});
                        m_row = (m_row + 1) % 8;
                        row_buf.delete();
                    end
                end
            end
        end
    endtask

    // Drives one cycle of inputs, lets the edge happen, then compares.
    task automatic applyStimulus(input bit v, input int d, input bit sof, input bit rn);
        bit ey;
        y_event_t ev;
        sample_t xo[8];
        rst_n = rn;
        pif.pix_valid = v;
        pif.pix_data = 8'(d);
        pif.pix_sof = sof;
        @(posedge clk);
        modelEdge(v, d, sof, rn);
        #1;
        xo = '{x0, x1, x2, x3, x4, x5, x6, x7};
        checkOutput("pix_ready", 32'(pif.pix_ready), 32'(m_ready));
        checkOutput("x_valid", 32'(x_valid), 32'(m_xvalid));
        checkOutput("x_last", 32'(x_last), 32'(m_xlast));
        checkOutput("sof_err", 32'(sof_err), 32'(m_sof_err));
        checkOutput("x_row", 32'(x_row), m_xrow);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("x%0d", i), 32'(xo[i]), m_x[i]);
        end
        ey = (yq.size() != 0 && yq[0].due == cyc);
        checkOutput("y_valid", 32'(y_valid), 32'(ey));
        if (ey) begin
            ev = yq.pop_front();
            checkOutput("y_row", 32'(y_row), ev.row);
            checkOutput("y_last", 32'(y_last), 32'(ev.last));
        end else begin
            checkOutput("y_last_idle", 32'(y_last), 0);
        end
    endtask

    initial begin
        int vals[4];
        rst_n = 1'b0;
        pif.pix_valid = 1'b0;
        pif.pix_data = '0;
        pif.pix_sof = 1'b0;
        m_ready = 0;

        // reset
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 55, 1, 1);  // ready still low: pixel dropped

        // full block of 64 continuous pixels
        for (int i = 0; i < 64; i++) applyStimulus(1, $urandom_range(0, 255), i == 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

        // one row of 200s with valid toggling
        for (int i = 0; i < 16; i++) applyStimulus(i % 2 == 0, 200, i == 0, 1);

        // ramp 128..135 starting a new block
        for (int i = 0; i < 8; i++) applyStimulus(1, 128 + i, i == 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

        // sof on the 4th pixel of row 2
        for (int i = 0; i < 19; i++) applyStimulus(1, $urandom_range(0, 255), i == 0, 1);
        applyStimulus(1, 77, 1, 1);
        for (int i = 0; i < 7; i++) applyStimulus(1, i * 30, 0, 1);
        applyStimulus(0, 0, 1, 1);  // sof without valid is ignored
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

        // reset mid-row with rows still in the delay line
        for (int i = 0; i < 16; i++) applyStimulus(1, $urandom_range(0, 255), i == 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(1, $urandom_range(0, 255), 0, 1);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, $urandom_range(0, 255), i == 1, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

        // signed interpretation corner values
        vals = '{8'h80, 8'h7F, 8'hC8, 0};
        for (int i = 0; i < 8; i++) applyStimulus(1, (i < 4) ? vals[i] : i, i == 0, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);

        // random traffic with occasional sof and reset
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 255),
                          $urandom_range(0, 29) == 0, $urandom_range(0, 99) != 0);
        end
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
